bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 128 ++++++++++++
 tb/tb_bus_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Shared-bus arbiter between a CPU and a video fetch unit: warns the CPU via ba,
// hands the bus to video for a capped burst, then forces a CPU holdoff slot.
module bus_arbiter #(
    parameter int WARN_CYCLES = 3,
    parameter int MAX_BURST   = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_ab,
    input  logic        cpu_we,
    input  logic        vid_req,
    input  logic [15:0] vid_ab,
    output logic [15:0] mem_ab,
    output logic        mem_we,
    output logic        ba,
    output logic        rdy,
    output logic        aec,
    output logic        vid_ack,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        ST_CPU     = 2'd0,
        ST_WARN    = 2'd1,
        ST_VID     = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    localparam logic [1:0] WARN_LAST  = 2'(WARN_CYCLES - 1);
    localparam logic [5:0] BURST_LAST = 6'(MAX_BURST - 1);

    state_t      state_q, state_d;
    logic [1:0]  warn_cnt_q, warn_cnt_d;
    logic [5:0]  burst_cnt_q, burst_cnt_d;
    logic [15:0] stall_count_q, stall_count_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_CPU;
            warn_cnt_q    <= 2'd0;
            burst_cnt_q   <= 6'd0;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            warn_cnt_q    <= warn_cnt_d;
            burst_cnt_q   <= burst_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        warn_cnt_d  = warn_cnt_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ST_CPU: begin
                if (vid_req) begin
                    state_d    = ST_WARN;
                    warn_cnt_d = 2'd0;
                end
            end
            ST_WARN: begin
                if (!vid_req) begin
                    state_d = ST_CPU;
                end else if (warn_cnt_q == WARN_LAST) begin
                    state_d     = ST_VID;
                    burst_cnt_d = 6'd0;
                end else begin
                    warn_cnt_d = warn_cnt_q + 2'd1;
                end
            end
            ST_VID: begin
                if (!vid_req) begin
                    state_d = ST_CPU;
                end else if (burst_cnt_q == BURST_LAST) begin
                    state_d = ST_HOLDOFF;
                end else begin
                    burst_cnt_d = burst_cnt_q + 6'd1;
                end
            end
            default: begin
                // Holdoff guarantees the CPU one full cycle between capped bursts.
                if (vid_req) begin
                    state_d    = ST_WARN;
                    warn_cnt_d = 2'd0;
                end else begin
                    state_d = ST_CPU;
                end
            end
        endcase
    end

    always_comb begin
        ba      = 1'b1;
        rdy     = 1'b1;
        aec     = 1'b1;
        vid_ack = 1'b0;
        mem_ab  = cpu_ab;
        mem_we  = cpu_we;
        case (state_q)
            ST_WARN: begin
                // CPU writes still go through; only reads are stalled.
                ba  = 1'b0;
                rdy = 1'b0;
            end
            ST_VID: begin
                ba      = 1'b0;
                rdy     = 1'b0;
                aec     = 1'b0;
                vid_ack = 1'b1;
                mem_ab  = vid_ab;
                mem_we  = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!rdy && stall_count_q != 16'hFFFF) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: per-cycle vector tables (expected state per cycle) fed
// through a scoreboard queue, plus a hand-written asynchronous-reset sequence.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_ab, vid_ab;
    logic        cpu_we, vid_req;

    logic [15:0] mem_ab_a, stall_a, mem_ab_b, stall_b;
    logic        mem_we_a, ba_a, rdy_a, aec_a, ack_a;
    logic        mem_we_b, ba_b, rdy_b, aec_b, ack_b;

    always #5 clk = ~clk;

    bus_arbiter dut_a (
        .clk(clk), .reset(reset), .cpu_ab(cpu_ab), .cpu_we(cpu_we),
        .vid_req(vid_req), .vid_ab(vid_ab), .mem_ab(mem_ab_a), .mem_we(mem_we_a),
        .ba(ba_a), .rdy(rdy_a), .aec(aec_a), .vid_ack(ack_a), .stall_count(stall_a)
    );

    bus_arbiter #(.WARN_CYCLES(3), .MAX_BURST(4)) dut_b (
        .clk(clk), .reset(reset), .cpu_ab(cpu_ab), .cpu_we(cpu_we),
        .vid_req(vid_req), .vid_ab(vid_ab), .mem_ab(mem_ab_b), .mem_we(mem_we_b),
        .ba(ba_b), .rdy(rdy_b), .aec(aec_b), .vid_ack(ack_b), .stall_count(stall_b)
    );

    typedef struct {
        bit          sel;
        bit          vid_req;
        bit          cpu_we;
        logic [15:0] cpu_ab;
        logic [15:0] vid_ab;
        byte         st;
    } vec_t;

    typedef struct {
        bit          sel;
        int          idx;
        logic        ba, rdy, aec, ack, we;
        logic [15:0] ab;
        logic [15:0] stall;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] stall_exp;

    task automatic chk(input string name, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input bit sel, input bit req, input bit we,
                       input logic [15:0] cab, input logic [15:0] vab, input byte st);
        vec_t v;
        v.sel = sel; v.vid_req = req; v.cpu_we = we;
        v.cpu_ab = cab; v.vid_ab = vab; v.st = st;
        vecs.push_back(v);
    endtask

    // Leaves the bench at posedge+1 with reset released and the DUTs in CPU state.
    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; vid_req = 1'b0; cpu_we = 1'b0; cpu_ab = 16'h0000; vid_ab = 16'h0000;
        @(negedge clk);
        chk("rst_ba", 0, {15'd0, ba_a}, 16'd1);
        chk("rst_rdy", 0, {15'd0, rdy_a}, 16'd1);
        chk("rst_aec", 0, {15'd0, aec_a}, 16'd1);
        chk("rst_ack", 0, {15'd0, ack_a}, 16'd0);
        chk("rst_stall", 0, stall_a, 16'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        stall_exp = 16'd0;
    endtask

    task automatic apply(input string name);
        exp_t e, g;
        for (int i = 0; i < vecs.size(); i++) begin
            vid_req = vecs[i].vid_req;
            cpu_we  = vecs[i].cpu_we;
            cpu_ab  = vecs[i].cpu_ab;
            vid_ab  = vecs[i].vid_ab;
            e.sel = vecs[i].sel; e.idx = i; e.stall = stall_exp;
            e.ba = 1'b1; e.rdy = 1'b1; e.aec = 1'b1; e.ack = 1'b0;
            e.ab = vecs[i].cpu_ab; e.we = vecs[i].cpu_we;
            case (vecs[i].st)
                "W": begin e.ba = 1'b0; e.rdy = 1'b0; end
                "V": begin
                    e.ba = 1'b0; e.rdy = 1'b0; e.aec = 1'b0; e.ack = 1'b1;
                    e.ab = vecs[i].vid_ab; e.we = 1'b0;
                end
                default: begin end
            endcase
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            if (e.sel) begin
                g.ba = ba_b; g.rdy = rdy_b; g.aec = aec_b; g.ack = ack_b;
                g.we = mem_we_b; g.ab = mem_ab_b; g.stall = stall_b;
            end else begin
                g.ba = ba_a; g.rdy = rdy_a; g.aec = aec_a; g.ack = ack_a;
                g.we = mem_we_a; g.ab = mem_ab_a; g.stall = stall_a;
            end
            $display("[TB] %s cyc %0d st %s req %0d ab %h we %0d ack %0d stall %0d",
                     name, i, string'(vecs[i].st), vecs[i].vid_req, g.ab, g.we, g.ack, g.stall);
            chk({name, "_ba"}, e.idx, {15'd0, g.ba}, {15'd0, e.ba});
            chk({name, "_rdy"}, e.idx, {15'd0, g.rdy}, {15'd0, e.rdy});
            chk({name, "_aec"}, e.idx, {15'd0, g.aec}, {15'd0, e.aec});
            chk({name, "_ack"}, e.idx, {15'd0, g.ack}, {15'd0, e.ack});
            chk({name, "_we"}, e.idx, {15'd0, g.we}, {15'd0, e.we});
            chk({name, "_ab"}, e.idx, g.ab, e.ab);
            chk({name, "_stall"}, e.idx, g.stall, e.stall);
            if (!e.rdy) stall_exp = stall_exp + 16'd1;
            @(posedge clk); #1;
        end
        vecs.delete();
    endtask

    initial begin
        reset = 1'b1; vid_req = 1'b0; cpu_we = 1'b0; cpu_ab = '0; vid_ab = '0;

        // Idle: CPU keeps the bus.
        do_reset();
        for (int i = 0; i < 10; i++) add(0, 0, 1, 16'h1234, 16'h0400, "C");
        apply("idle");

        // Nominal burst: 8 request cycles, video address moving during the burst.
        do_reset();
        add(0, 1, 0, 16'h2000, 16'h0400, "C");
        for (int i = 1; i <= 3; i++) add(0, 1, 0, 16'h2000 + 16'(i), 16'h0400, "W");
        for (int i = 4; i <= 7; i++) add(0, 1, 0, 16'h2000, 16'h0400 + 16'(i - 4), "V");
        add(0, 0, 0, 16'h2000, 16'h0410, "V");
        add(0, 0, 1, 16'h2001, 16'h0410, "C");
        add(0, 0, 0, 16'h2002, 16'h0410, "C");
        apply("burst");

        // Withdrawal after two warn cycles.
        do_reset();
        add(0, 1, 0, 16'h3000, 16'h0500, "C");
        add(0, 1, 0, 16'h3000, 16'h0500, "W");
        add(0, 0, 0, 16'h3000, 16'h0500, "W");
        add(0, 0, 0, 16'h3000, 16'h0500, "C");
        add(0, 0, 0, 16'h3000, 16'h0500, "C");
        apply("withdraw");

        // CPU write while warned completes; suppressed once video owns the bus.
        do_reset();
        add(0, 1, 1, 16'hD020, 16'h0600, "C");
        for (int i = 0; i < 3; i++) add(0, 1, 1, 16'hD020, 16'h0600, "W");
        add(0, 1, 1, 16'hD020, 16'h0600, "V");
        add(0, 0, 1, 16'hD020, 16'h0601, "V");
        add(0, 0, 1, 16'hD020, 16'h0601, "C");
        apply("wrwarn");

        // Burst cap (MAX_BURST=4): holdoff then re-warn, holdoff then idle.
        do_reset();
        add(1, 1, 0, 16'h4000, 16'h0700, "C");
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) add(1, 1, 0, 16'h4000, 16'h0700, "W");
            for (int i = 0; i < 4; i++) add(1, 1, 0, 16'h4000, 16'h0700 + 16'(i), "V");
            add(1, r == 0, 1, 16'h4001, 16'h0700, "H");
        end
        add(1, 0, 0, 16'h4002, 16'h0700, "C");
        apply("cap");

        // Asynchronous reset between edges while video owns the bus.
        do_reset();
        add(0, 1, 0, 16'h5000, 16'h0800, "C");
        for (int i = 0; i < 3; i++) add(0, 1, 0, 16'h5000, 16'h0800, "W");
        add(0, 1, 0, 16'h5000, 16'h0800, "V");
        add(0, 1, 0, 16'h5000, 16'h0801, "V");
        apply("prerst");
        chk("pre_ack", 0, {15'd0, ack_a}, 16'd1);
        cpu_we = 1'b0;
        #1 reset = 1'b1;
        #1;
        $display("[TB] async reset mid-VID ack %0d aec %0d stall %0d", ack_a, aec_a, stall_a);
        chk("arst_ack", 0, {15'd0, ack_a}, 16'd0);
        chk("arst_aec", 0, {15'd0, aec_a}, 16'd1);
        chk("arst_ba", 0, {15'd0, ba_a}, 16'd1);
        chk("arst_we", 0, {15'd0, mem_we_a}, 16'd0);
        chk("arst_ab", 0, mem_ab_a, 16'h5000);
        chk("arst_stall", 0, stall_a, 16'd0);
        @(posedge clk); #1;
        chk("arst_hold_ack", 0, {15'd0, ack_a}, 16'd0);
        reset = 1'b0;
        stall_exp = 16'd0;
        add(0, 1, 0, 16'h5100, 16'h0900, "C");
        add(0, 1, 0, 16'h5100, 16'h0900, "W");
        add(0, 0, 0, 16'h5100, 16'h0900, "W");
        add(0, 0, 0, 16'h5100, 16'h0900, "C");
        apply("postrst");

        chk("sb_empty", 0, 16'(sb.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
